ysyx_22040632_mul_ctrl: RTL and testbench



---
 rtl/ysyx_22040632_mul_pkg.sv | 38 +++
 rtl/ysyx_22040632_mul_fixup.sv | 36 +++
 rtl/ysyx_22040632_mul_ctrl.sv | 168 ++++++++++++++++
 tb/tb_ysyx_22040632_mul_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_22040632_mul_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_22040632_mul_pkg
// Shared types and constants for the RV64M multiply issue/writeback controller.
//   mul_op_e       : multiply opcode as presented on in_op
//   mul_state_e    : controller FSM states
//   MUL_SIGNED_*   : operand signedness code driven to the Booth/Wallace array
//                    (bit 1 = multiplicand signed, bit 0 = multiplier signed)
//   mul_signed_of  : signedness code for a given opcode
// ----------------------------------------------------------------------------
package ysyx_22040632_mul_pkg;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_MULW   = 3'd4
    } mul_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } mul_state_e;

    localparam logic [1:0] MUL_SIGNED_SS = 2'b11;
    localparam logic [1:0] MUL_SIGNED_UU = 2'b00;

    // Settle counter width; covers MUL_CYCLES up to 7.
    localparam int CNT_W = 3;

    // MULHSU is issued to the array as signed x signed and corrected
    // afterwards, so only MULHU needs the unsigned array mode.
    function automatic logic [1:0] mul_signed_of(input logic [2:0] op);
        return (op == OP_MULHU) ? MUL_SIGNED_UU : MUL_SIGNED_SS;
    endfunction

endpackage

// File: rtl/ysyx_22040632_mul_fixup.sv
// ----------------------------------------------------------------------------
// ysyx_22040632_mul_fixup
// Combinational result selection behind the multiplier array.
//   op       in  3     registered opcode (values 5..7 behave as MUL)
//   rs1      in  XLEN  registered multiplicand
//   rs2_sign in  1     sign bit of the registered multiplier
//   lo, hi   in  XLEN  product halves from the multiplier
//   data     out XLEN  final rd value
// ----------------------------------------------------------------------------
module ysyx_22040632_mul_fixup
    import ysyx_22040632_mul_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic            rs2_sign,
    input  logic [XLEN-1:0] lo,
    input  logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] data
);

    always_comb begin
        data = lo;
        case (op)
            OP_MULH, OP_MULHU: data = hi;
            // The array ran signed x signed. Reinterpreting a negative rs2 as
            // unsigned adds 2^XLEN * rs1 to the product, i.e. rs1 to the
            // high half.
            OP_MULHSU:         data = hi + (rs2_sign ? rs1 : '0);
            OP_MULW:           data = {{(XLEN-32){lo[31]}}, lo[31:0]};
            default:           data = lo;
        endcase
    end

endmodule

// File: rtl/ysyx_22040632_mul_ctrl.sv
// ----------------------------------------------------------------------------
// ysyx_22040632_mul_ctrl
// Issue/writeback controller in front of a combinational multiplier. Accepts
// one operation over a valid/ready handshake, holds the operands stable while
// the multiplier settles for MUL_CYCLES cycles (1..7), then registers the
// corrected result and holds it until writeback takes it.
//   clk, rst                 clock, synchronous active-high reset
//   flush                    kills any in-flight operation; blocks accept
//   in_valid/in_ready        operation handshake (in_op, in_rs1, in_rs2, in_rd)
//   mul_multiplicand/
//   mul_multiplier/mul_mulw/
//   mul_signed               registered controls to the multiplier
//   mul_result_lo/hi         product halves from the multiplier
//   out_valid/out_ready      result handshake (out_data, out_rd)
// An operation accepted at one edge is visible on out_valid after MUL_CYCLES
// further edges; with out_ready held high a new operation can be accepted on
// the completion edge, giving one result every MUL_CYCLES+1 cycles.
// ----------------------------------------------------------------------------
module ysyx_22040632_mul_ctrl
    import ysyx_22040632_mul_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter int MUL_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_op,
    input  logic [XLEN-1:0] in_rs1,
    input  logic [XLEN-1:0] in_rs2,
    input  logic [4:0]      in_rd,
    output logic [XLEN-1:0] mul_multiplicand,
    output logic [XLEN-1:0] mul_multiplier,
    output logic            mul_mulw,
    output logic [1:0]      mul_signed,
    input  logic [XLEN-1:0] mul_result_lo,
    input  logic [XLEN-1:0] mul_result_hi,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_data,
    output logic [4:0]      out_rd
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - 1);

    mul_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [XLEN-1:0]   rs1_q, rs1_d;
    logic [XLEN-1:0]   rs2_q, rs2_d;
    logic [4:0]        rd_q, rd_d;
    logic              mulw_q, mulw_d;
    logic [1:0]        signed_q, signed_d;
    logic              out_valid_q, out_valid_d;
    logic [XLEN-1:0]   out_data_q, out_data_d;
    logic [4:0]        out_rd_q, out_rd_d;
    logic [XLEN-1:0]   fix_data;

    ysyx_22040632_mul_fixup #(
        .XLEN (XLEN)
    ) u_fixup (
        .op       (op_q),
        .rs1      (rs1_q),
        .rs2_sign (rs2_q[XLEN-1]),
        .lo       (mul_result_lo),
        .hi       (mul_result_hi),
        .data     (fix_data)
    );

    // A slot is free when idle, or when the held result leaves this cycle.
    assign in_ready = !flush && ((state_q == ST_IDLE) ||
                                 (state_q == ST_DONE && out_ready));

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rd_d        = rd_q;
        mulw_d      = mulw_q;
        signed_d    = signed_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_rd_d    = out_rd_q;

        if (flush) begin
            // Operand and result registers are left alone; only the
            // sequencing is abandoned.
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                ST_CALC: begin
                    if (cnt_q == '0) begin
                        state_d     = ST_DONE;
                        out_valid_d = 1'b1;
                        out_data_d  = fix_data;
                        out_rd_d    = rd_q;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_d     = ST_IDLE;
                        out_valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            // Accept is common to IDLE and the completing DONE cycle.
            if (in_valid && in_ready) begin
                state_d     = ST_CALC;
                cnt_d       = CNT_LOAD;
                op_d        = in_op;
                rs1_d       = in_rs1;
                rs2_d       = in_rs2;
                rd_d        = in_rd;
                mulw_d      = (in_op == OP_MULW);
                signed_d    = mul_signed_of(in_op);
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            op_q        <= OP_MUL;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            mulw_q      <= 1'b0;
            signed_q    <= MUL_SIGNED_SS;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_rd_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            mulw_q      <= mulw_d;
            signed_q    <= signed_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_rd_q    <= out_rd_d;
        end
    end

    assign mul_multiplicand = rs1_q;
    assign mul_multiplier   = rs2_q;
    assign mul_mulw         = mulw_q;
    assign mul_signed       = signed_q;
    assign out_valid        = out_valid_q;
    assign out_data         = out_data_q;
    assign out_rd           = out_rd_q;

endmodule

// File: tb/tb_ysyx_22040632_mul_ctrl.sv
// ----------------------------------------------------------------------------
// Bench for ysyx_22040632_mul_ctrl. A behavioural multiplier closes the loop
// on the DUT's multiplier port; expected results come from an RV64M reference
// function written directly from the instruction semantics.
// ----------------------------------------------------------------------------
module tb_ysyx_22040632_mul_ctrl;

    localparam int XLEN       = 64;
    localparam int MUL_CYCLES = 2;

    logic            clk;
    logic            rst;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      in_op;
    logic [63:0]     in_rs1;
    logic [63:0]     in_rs2;
    logic [4:0]      in_rd;
    logic [63:0]     mul_multiplicand;
    logic [63:0]     mul_multiplier;
    logic            mul_mulw;
    logic [1:0]      mul_signed;
    logic [63:0]     mul_result_lo;
    logic [63:0]     mul_result_hi;
    logic            out_valid;
    logic            out_ready;
    logic [63:0]     out_data;
    logic [4:0]      out_rd;

    int pass_cnt  = 0;
    int check_cnt = 0;

    ysyx_22040632_mul_ctrl #(
        .XLEN       (XLEN),
        .MUL_CYCLES (MUL_CYCLES)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .flush            (flush),
        .in_valid         (in_valid),
        .in_ready         (in_ready),
        .in_op            (in_op),
        .in_rs1           (in_rs1),
        .in_rs2           (in_rs2),
        .in_rd            (in_rd),
        .mul_multiplicand (mul_multiplicand),
        .mul_multiplier   (mul_multiplier),
        .mul_mulw         (mul_mulw),
        .mul_signed       (mul_signed),
        .mul_result_lo    (mul_result_lo),
        .mul_result_hi    (mul_result_hi),
        .out_valid        (out_valid),
        .out_ready        (out_ready),
        .out_data         (out_data),
        .out_rd           (out_rd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural multiplier: 128-bit product with per-operand signedness.
    logic [127:0] ext_a, ext_b, prod;
    always_comb begin
        ext_a = mul_signed[1] ? {{64{mul_multiplicand[63]}}, mul_multiplicand} : {64'd0, mul_multiplicand};
        ext_b = mul_signed[0] ? {{64{mul_multiplier[63]}}, mul_multiplier} : {64'd0, mul_multiplier};
        prod  = ext_a * ext_b;
    end
    assign mul_result_lo = prod[63:0];
    assign mul_result_hi = prod[127:64];

    // RV64M reference semantics.
    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
        logic [127:0] sa, za, sb, zb, p;
        logic [63:0]  lo;
        sa = {{64{a[63]}}, a};
        za = {64'd0, a};
        sb = {{64{b[63]}}, b};
        zb = {64'd0, b};
        lo = a * b;
        case (op)
            3'd1: begin p = sa * sb; return p[127:64]; end
            3'd2: begin p = sa * zb; return p[127:64]; end
            3'd3: begin p = za * zb; return p[127:64]; end
            3'd4: return {{32{lo[31]}}, lo[31:0]};
            default: return lo;
        endcase
    endfunction

    function automatic logic [63:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 64'd0;
            1: return 64'hFFFF_FFFF_FFFF_FFFF;
            2: return 64'h8000_0000_0000_0000;
            3: return 64'h7FFF_FFFF_FFFF_FFFF;
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one op from IDLE, wait (bounded) for the result, snapshot the
    // outputs while valid, then retire it. lat = edges after the accept edge.
    task automatic issue_wait(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                              input logic [4:0] rd, output int lat, output logic [63:0] data,
                              output logic [4:0] ord, output logic [63:0] mc, output logic [63:0] mr,
                              output logic mw, output logic [1:0] ms);
        in_op = op; in_rs1 = a; in_rs2 = b; in_rd = rd;
        in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        data = out_data; ord = out_rd;
        mc = mul_multiplicand; mr = mul_multiplier; mw = mul_mulw; ms = mul_signed;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        #1;
        check_cnt++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %0b want 0", out_valid); else pass_cnt++;
        check_cnt++; if (out_data !== 64'd0) $display("FAIL reset_out_data got %h want 0", out_data); else pass_cnt++;
        check_cnt++; if (out_rd !== 5'd0) $display("FAIL reset_out_rd got %0d want 0", out_rd); else pass_cnt++;
        check_cnt++; if (mul_multiplicand !== 64'd0) $display("FAIL reset_multiplicand got %h want 0", mul_multiplicand); else pass_cnt++;
        check_cnt++; if (mul_multiplier !== 64'd0) $display("FAIL reset_multiplier got %h want 0", mul_multiplier); else pass_cnt++;
        check_cnt++; if (mul_mulw !== 1'b0) $display("FAIL reset_mulw got %0b want 0", mul_mulw); else pass_cnt++;
        check_cnt++; if (mul_signed !== 2'b11) $display("FAIL reset_signed got %b want 11", mul_signed); else pass_cnt++;
        check_cnt++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %0b want 1", in_ready); else pass_cnt++;
    endtask

    task automatic test_directed();
        logic [2:0]  ops [6] = '{3'd0, 3'd1, 3'd3, 3'd3, 3'd2, 3'd4};
        logic [63:0] as  [6] = '{64'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                                 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF};
        logic [63:0] bs  [6] = '{64'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                                 64'd2, 64'h8000_0000_0000_0000, 64'd2};
        logic [63:0] exs [6] = '{64'd15, 64'd0, 64'hFFFF_FFFF_FFFF_FFFE,
                                 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE};
        int lat; logic [63:0] data, mc, mr; logic [4:0] ord; logic mw; logic [1:0] ms;
        for (int i = 0; i < 6; i++) begin
            issue_wait(ops[i], as[i], bs[i], 5'(i + 7), lat, data, ord, mc, mr, mw, ms);
            $display("directed op=%0d a=%h b=%h rd=%0d -> data=%h lat=%0d", ops[i], as[i], bs[i], i + 7, data, lat);
            check_cnt++; if (data !== exs[i]) $display("FAIL directed_data[%0d] got %h want %h", i, data, exs[i]); else pass_cnt++;
            check_cnt++; if (ord !== 5'(i + 7)) $display("FAIL directed_rd[%0d] got %0d want %0d", i, ord, i + 7); else pass_cnt++;
            check_cnt++; if (lat !== MUL_CYCLES) $display("FAIL directed_latency[%0d] got %0d want %0d", i, lat, MUL_CYCLES); else pass_cnt++;
        end
    endtask

    task automatic test_random();
        int lat; logic [63:0] data, mc, mr, a, b, exp; logic [4:0] ord, rd; logic mw; logic [1:0] ms, exp_ms;
        logic [2:0] op;
        for (int i = 0; i < 30; i++) begin
            op = 3'($urandom_range(0, 7));
            a = pick_operand(); b = pick_operand(); rd = 5'($urandom_range(0, 31));
            exp = ref_result(op, a, b);
            exp_ms = (op == 3'd3) ? 2'b00 : 2'b11;
            issue_wait(op, a, b, rd, lat, data, ord, mc, mr, mw, ms);
            $display("random op=%0d a=%h b=%h rd=%0d -> data=%h", op, a, b, rd, data);
            check_cnt++; if (data !== exp) $display("FAIL random_data op=%0d got %h want %h", op, data, exp); else pass_cnt++;
            check_cnt++; if (ord !== rd) $display("FAIL random_rd got %0d want %0d", ord, rd); else pass_cnt++;
            check_cnt++; if (lat !== MUL_CYCLES) $display("FAIL random_latency got %0d want %0d", lat, MUL_CYCLES); else pass_cnt++;
            check_cnt++; if (mc !== a) $display("FAIL random_multiplicand got %h want %h", mc, a); else pass_cnt++;
            check_cnt++; if (mr !== b) $display("FAIL random_multiplier got %h want %h", mr, b); else pass_cnt++;
            check_cnt++; if (mw !== (op == 3'd4)) $display("FAIL random_mulw op=%0d got %0b", op, mw); else pass_cnt++;
            check_cnt++; if (ms !== exp_ms) $display("FAIL random_signed op=%0d got %b want %b", op, ms, exp_ms); else pass_cnt++;
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] a0, b0, a1, b1, exp0, exp1; int lat;
        a0 = pick_operand(); b0 = {$urandom, $urandom}; a1 = {$urandom, $urandom}; b1 = pick_operand();
        exp0 = ref_result(3'd2, a0, b0);
        exp1 = ref_result(3'd1, a1, b1);
        in_op = 3'd2; in_rs1 = a0; in_rs2 = b0; in_rd = 5'd12; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin tick(); lat++; end
        check_cnt++; if (lat !== MUL_CYCLES) $display("FAIL bp_latency got %0d want %0d", lat, MUL_CYCLES); else pass_cnt++;
        // Next op is offered while writeback stalls.
        in_op = 3'd1; in_rs1 = a1; in_rs2 = b1; in_rd = 5'd21; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            check_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready[%0d] got %0b want 0", i, in_ready); else pass_cnt++;
            tick();
            check_cnt++; if (out_valid !== 1'b1) $display("FAIL bp_out_valid[%0d] got %0b want 1", i, out_valid); else pass_cnt++;
            check_cnt++; if (out_data !== exp0) $display("FAIL bp_hold_data[%0d] got %h want %h", i, out_data, exp0); else pass_cnt++;
            check_cnt++; if (out_rd !== 5'd12) $display("FAIL bp_hold_rd[%0d] got %0d want 12", i, out_rd); else pass_cnt++;
        end
        out_ready = 1'b1;
        #1;
        check_cnt++; if (in_ready !== 1'b1) $display("FAIL bp_release_in_ready got %0b want 1", in_ready); else pass_cnt++;
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin tick(); lat++; end
        $display("backpressure second op -> data=%h lat=%0d", out_data, lat);
        check_cnt++; if (lat !== MUL_CYCLES) $display("FAIL bp_b2b_latency got %0d want %0d", lat, MUL_CYCLES); else pass_cnt++;
        check_cnt++; if (out_data !== exp1) $display("FAIL bp_b2b_data got %h want %h", out_data, exp1); else pass_cnt++;
        check_cnt++; if (out_rd !== 5'd21) $display("FAIL bp_b2b_rd got %0d want 21", out_rd); else pass_cnt++;
        out_ready = 1'b1; tick(); out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [63:0] exp_q[$];
        logic [4:0]  rd_exp_q[$];
        logic [63:0] a, b, e; logic [4:0] r;
        logic [2:0]  op;
        int n = 6, issued = 0, got = 0, last = -1, cyc = 0;
        bit acc;
        op = 3'($urandom_range(0, 4)); a = pick_operand(); b = pick_operand();
        in_op = op; in_rs1 = a; in_rs2 = b; in_rd = 5'd1;
        in_valid = 1'b1; out_ready = 1'b1;
        while (got < n && cyc < 200) begin
            #1;
            acc = in_valid && in_ready;
            tick();
            cyc++;
            if (acc) begin
                exp_q.push_back(ref_result(op, a, b));
                rd_exp_q.push_back(in_rd);
                issued++;
                if (issued < n) begin
                    op = 3'($urandom_range(0, 4)); a = pick_operand(); b = pick_operand();
                    in_op = op; in_rs1 = a; in_rs2 = b; in_rd = 5'(issued + 1);
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (out_valid === 1'b1) begin
                got++;
                e = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hDEAD;
                r = (rd_exp_q.size() > 0) ? rd_exp_q.pop_front() : 5'd0;
                $display("b2b result %0d data=%h rd=%0d cycle=%0d", got, out_data, out_rd, cyc);
                check_cnt++; if (out_data !== e) $display("FAIL b2b_data[%0d] got %h want %h", got, out_data, e); else pass_cnt++;
                check_cnt++; if (out_rd !== r) $display("FAIL b2b_rd[%0d] got %0d want %0d", got, out_rd, r); else pass_cnt++;
                if (last >= 0) begin
                    check_cnt++; if (cyc - last !== MUL_CYCLES + 1) $display("FAIL b2b_interval[%0d] got %0d want %0d", got, cyc - last, MUL_CYCLES + 1); else pass_cnt++;
                end
                last = cyc;
            end
        end
        check_cnt++; if (got !== n) $display("FAIL b2b_count got %0d want %0d", got, n); else pass_cnt++;
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_flush();
        logic [63:0] a; bit seen; int lat;
        a = {$urandom, $urandom} | 64'h1;
        // Flush in the first CALC cycle.
        in_op = 3'd0; in_rs1 = a; in_rs2 = 64'd9; in_rd = 5'd3; in_valid = 1'b1; out_ready = 1'b1;
        tick();
        in_valid = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        check_cnt++; if (out_valid !== 1'b0) $display("FAIL flush_calc_out_valid got %0b want 0", out_valid); else pass_cnt++;
        check_cnt++; if (in_ready !== 1'b1) $display("FAIL flush_calc_idle in_ready got %0b want 1", in_ready); else pass_cnt++;
        seen = 0;
        for (int i = 0; i < MUL_CYCLES + 3; i++) begin tick(); if (out_valid !== 1'b0) seen = 1; end
        check_cnt++; if (seen) $display("FAIL flush_calc_no_result got valid want none"); else pass_cnt++;
        // Flush together with an offer in IDLE.
        in_op = 3'd3; in_rs1 = ~a; in_rs2 = 64'd5; in_rd = 5'd4; in_valid = 1'b1; flush = 1'b1;
        #1;
        check_cnt++; if (in_ready !== 1'b0) $display("FAIL flush_idle_in_ready got %0b want 0", in_ready); else pass_cnt++;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        check_cnt++; if (mul_multiplicand !== a) $display("FAIL flush_idle_operand got %h want %h", mul_multiplicand, a); else pass_cnt++;
        seen = 0;
        for (int i = 0; i < MUL_CYCLES + 3; i++) begin tick(); if (out_valid !== 1'b0) seen = 1; end
        check_cnt++; if (seen) $display("FAIL flush_idle_no_result got valid want none"); else pass_cnt++;
        // Flush while a result is held.
        in_op = 3'd0; in_rs1 = 64'd6; in_rs2 = 64'd7; in_rd = 5'd5; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin tick(); lat++; end
        flush = 1'b1; out_ready = 1'b1;
        tick();
        flush = 1'b0; out_ready = 1'b0;
        check_cnt++; if (out_valid !== 1'b0) $display("FAIL flush_done_out_valid got %0b want 0", out_valid); else pass_cnt++;
    endtask

    task automatic test_rst_done();
        int lat;
        in_op = 3'd3; in_rs1 = 64'hFFFF_FFFF_FFFF_FFFF; in_rs2 = 64'd3; in_rd = 5'd30; in_valid = 1'b1; out_ready = 1'b0;
        tick();
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin tick(); lat++; end
        check_cnt++; if (out_data !== 64'd2) $display("FAIL rst_pre_data got %h want 2", out_data); else pass_cnt++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_done_out_valid got %0b want 0", out_valid); else pass_cnt++;
        check_cnt++; if (out_data !== 64'd0) $display("FAIL rst_done_out_data got %h want 0", out_data); else pass_cnt++;
        check_cnt++; if (out_rd !== 5'd0) $display("FAIL rst_done_out_rd got %0d want 0", out_rd); else pass_cnt++;
        check_cnt++; if (mul_multiplicand !== 64'd0) $display("FAIL rst_done_multiplicand got %h want 0", mul_multiplicand); else pass_cnt++;
        check_cnt++; if (mul_multiplier !== 64'd0) $display("FAIL rst_done_multiplier got %h want 0", mul_multiplier); else pass_cnt++;
        check_cnt++; if (mul_signed !== 2'b11) $display("FAIL rst_done_signed got %b want 11", mul_signed); else pass_cnt++;
        check_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_done_in_ready got %0b want 1", in_ready); else pass_cnt++;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_op = 3'd0; in_rs1 = '0; in_rs2 = '0; in_rd = '0;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_flush();
        test_rst_done();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
